pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Parameters
REQ-001 ADDR_W, default 32, PC/address width; legal range 16..64.
REQ-002 RESET_VEC, default 0, cur_pc value on reset.
REQ-003 RAS_DEPTH, default 4, return-address-stack entries; power of 2, range 2..16.
REQ-004 HALT_EN, default 0, 1 enables halt-address detection.
REQ-005 HALT_ADDR, default 20, PC value that halts fetch when HALT_EN=1.

Interface
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 stall  in  1  hazard stall; holds PC and RAS.
REQ-009 exc_req  in  1  exception redirect request.
REQ-010 exc_vec  in  ADDR_W  exception vector address.
REQ-011 br_taken  in  1  conditional branch resolved taken.
REQ-012 br_addr  in  ADDR_W  branch target.
REQ-013 jmp  in  1  absolute jump (J/JAL).
REQ-014 jmp_imm  in  26  jump immediate field.
REQ-015 call  in  1  JAL: push pc_plus_4 onto RAS.
REQ-016 ret  in  1  JR $ra: pop RAS, use as target.
REQ-017 jr_addr  in  ADDR_W  register target, used when RAS is empty.
REQ-018 resume  in  1  leave HALTED state.
REQ-019 cur_pc  out  ADDR_W  registered current PC.
REQ-020 pc_plus_4  out  ADDR_W  cur_pc+4, modulo 2^ADDR_W.
REQ-021 nxt_pc  out  ADDR_W  combinational next-PC selection.
REQ-022 ras_top  out  ADDR_W  top RAS entry; 0 when empty.
REQ-023 ras_empty / ras_full  out  1 each  RAS occupancy flags.
REQ-024 halted  out  1  high while in HALTED state.

Function
REQ-025 nxt_pc priority: exc_req -> exc_vec; ret -> ras_top (jr_addr if empty); jmp -> {pc_plus_4[ADDR_W-1:28], jmp_imm, 2'b00}; br_taken -> br_addr; else pc_plus_4.
REQ-026 br_taken is ignored while stall=1; exc_req is never masked by stall.
REQ-027 State machine: RUN, HALTED; halted=1 exactly in HALTED.
REQ-028 RUN, stall=0: cur_pc <= nxt_pc next edge; stall=1 and no exc_req: cur_pc held.
REQ-029 RUN -> HALTED when HALT_EN=1, stall=0, exc_req=0, nxt_pc==HALT_ADDR; cur_pc loads HALT_ADDR the same edge.
REQ-030 HALTED: cur_pc held, RAS frozen; resume -> RUN with cur_pc <= HALT_ADDR+4; exc_req -> RUN with cur_pc <= exc_vec (exc_req wins over resume).
REQ-031 RAS updates only in RUN with stall=0 and exc_req=0.
REQ-032 call alone: push pc_plus_4; count+1; when full, overwrite oldest entry circularly, count stays RAS_DEPTH.
REQ-033 ret alone: pop; count-1; pop on empty leaves count 0 and selects jr_addr.
REQ-034 call and ret together: top entry replaced by pc_plus_4, count unchanged (on empty: push, count=1).
REQ-035 exc_req (any state, regardless of stall) flushes RAS: count <= 0 next edge.
REQ-036 All address arithmetic wraps modulo 2^ADDR_W; no overflow flag.
REQ-037 nxt_pc, pc_plus_4, ras_top are combinational from registered state and inputs; zero-cycle latency.

Reset
REQ-038 rst=1 asynchronously forces cur_pc=RESET_VEC, state=RUN, halted=0, RAS count=0, ras_empty=1, ras_full=0, ras_top=0.
REQ-039 rst asserted mid-operation (including HALTED, mid-stall) discards all state; first edge after deassert fetches from RESET_VEC+4 path per REQ-025.
REQ-040 RAS storage contents need not be cleared; only count is reset.

Verification
REQ-041 Reset then 3 free-running cycles -> cur_pc 0, 4, 8, 12.
REQ-042 cur_pc=0x40, br_taken=1, br_addr=0x100, stall=1 -> cur_pc stays 0x40; stall=0 next cycle -> cur_pc 0x100.
REQ-043 RAS_DEPTH=4: 5 calls at PCs 0x10,0x20,0x30,0x40,0x50 then 5 rets -> targets 0x54,0x44,0x34,0x24 then jr_addr; ras_full=1 after 4th call, ras_empty=1 after 4th ret.
REQ-044 exc_req=1 with jmp=1, ret=1, stall=1, exc_vec=0x180 -> cur_pc 0x180 next edge, ras_empty=1.
REQ-045 HALT_EN=1, HALT_ADDR=20: run from reset -> halted=1 with cur_pc=20 after 5 edges; held 10 cycles; resume -> cur_pc 24, halted=0.
REQ-046 ADDR_W=16, cur_pc=0xFFFC, no control -> cur_pc 0x0000; rst pulsed mid-HALTED -> cur_pc=RESET_VEC, halted=0 immediately.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: instruction fetch program-counter generator.
//
// Keeps the registered fetch PC, picks the next PC from exception /
// return / jump / branch / sequential sources, maintains a circular
// return-address stack (RAS) for call/return prediction and can park
// fetch at a fixed halt address until resumed.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   stall      : hazard stall, holds PC and RAS (exceptions still apply)
//   exc_req    : exception redirect to exc_vec, also flushes the RAS
//   exc_vec    : exception vector address
//   br_taken   : resolved-taken conditional branch (ignored while stalled)
//   br_addr    : branch target
//   jmp        : absolute jump, target built from jmp_imm
//   jmp_imm    : 26-bit jump immediate (word index within the region)
//   call       : push pc_plus_4 onto the RAS
//   ret        : pop the RAS and use it as the target
//   jr_addr    : register target used when a return finds the RAS empty
//   resume     : leave the halted state
//   cur_pc     : registered current PC
//   pc_plus_4  : cur_pc + 4 (wrapping)
//   nxt_pc     : combinational next-PC selection
//   ras_top    : top RAS entry, zero when empty
//   ras_empty  : RAS holds no entries
//   ras_full   : RAS holds RAS_DEPTH entries
//   halted     : fetch is parked at HALT_ADDR
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter bit                HALT_EN   = 1'b0,
    parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(20)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_vec,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              jmp,
    input  logic [25:0]       jmp_imm,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              resume,
    output logic [ADDR_W-1:0] cur_pc,
    output logic [ADDR_W-1:0] pc_plus_4,
    output logic [ADDR_W-1:0] nxt_pc,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              halted
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // RAS: circular buffer, top_q points at the newest entry. A push while
    // full simply advances the pointer onto the oldest slot, which is how
    // the oldest entry gets overwritten without any shifting.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ras_we;
    logic [PTR_W-1:0]  ras_wptr;

    logic [27:0]       jmp_field;
    logic [ADDR_W-1:0] jmp_target;

    // ------------------------------------------------------------------
    // Datapath outputs
    // ------------------------------------------------------------------
    assign cur_pc    = pc_q;
    assign pc_plus_4 = pc_q + ADDR_W'(4);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[top_q];
    assign halted    = (state_q == HALTED);

    // Jump target keeps the region bits of pc_plus_4 above bit 27; narrow
    // PCs have no region bits and take the low part of the immediate only.
    assign jmp_field = {jmp_imm, 2'b00};

    if (ADDR_W > 28) begin : g_jmp_wide
        assign jmp_target = {pc_plus_4[ADDR_W-1:28], jmp_field};
    end else begin : g_jmp_narrow
        assign jmp_target = jmp_field[ADDR_W-1:0];
    end

    // ------------------------------------------------------------------
    // Next-PC priority select
    // ------------------------------------------------------------------
    always_comb begin
        nxt_pc = pc_plus_4;
        if (exc_req) begin
            nxt_pc = exc_vec;
        end else if (ret) begin
            nxt_pc = ras_empty ? jr_addr : ras_top;
        end else if (jmp) begin
            nxt_pc = jmp_target;
        end else if (br_taken && !stall) begin
            nxt_pc = br_addr;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
            top_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAS storage carries no reset; only the occupancy count matters.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem[ras_wptr] <= pc_plus_4;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, PC update and RAS control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        top_d    = top_q;
        cnt_d    = cnt_q;
        ras_we   = 1'b0;
        ras_wptr = top_q;

        if (exc_req) begin
            // Exceptions redirect from any state, even under stall.
            state_d = RUN;
            pc_d    = exc_vec;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall) begin
                        pc_d = nxt_pc;
                        if (HALT_EN && (nxt_pc == HALT_ADDR)) begin
                            state_d = HALTED;
                        end
                        if (call && ret) begin
                            // Replace in place; on empty the same slot
                            // becomes the single valid entry.
                            ras_we   = 1'b1;
                            ras_wptr = top_q;
                            if (ras_empty) begin
                                cnt_d = CNT_W'(1);
                            end
                        end else if (call) begin
                            ras_we   = 1'b1;
                            ras_wptr = top_q + PTR_W'(1);
                            top_d    = top_q + PTR_W'(1);
                            if (!ras_full) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end else if (ret && !ras_empty) begin
                            top_d = top_q - PTR_W'(1);
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_d = RUN;
                        pc_d    = HALT_ADDR + ADDR_W'(4);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios followed by randomized checking of two
// pc_gen instances (32-bit with HALT_ADDR=20, 16-bit with HALT_ADDR=0x100)
// against a behavioural model that keeps the RAS as a plain bounded stack.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        exc_req;
    logic [31:0] exc_vec;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        jmp;
    logic [25:0] jmp_imm;
    logic        call;
    logic        ret;
    logic [31:0] jr_addr;
    logic        resume;

    logic [31:0] cur_pc_a, pc_plus_4_a, nxt_pc_a, ras_top_a;
    logic        ras_empty_a, ras_full_a, halted_a;
    logic [15:0] cur_pc_b, pc_plus_4_b, nxt_pc_b, ras_top_b;
    logic        ras_empty_b, ras_full_b, halted_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pc_gen #(
        .ADDR_W   (32),
        .RESET_VEC(32'h0),
        .RAS_DEPTH(4),
        .HALT_EN  (1'b1),
        .HALT_ADDR(32'd20)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .exc_req  (exc_req),
        .exc_vec  (exc_vec),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .jmp      (jmp),
        .jmp_imm  (jmp_imm),
        .call     (call),
        .ret      (ret),
        .jr_addr  (jr_addr),
        .resume   (resume),
        .cur_pc   (cur_pc_a),
        .pc_plus_4(pc_plus_4_a),
        .nxt_pc   (nxt_pc_a),
        .ras_top  (ras_top_a),
        .ras_empty(ras_empty_a),
        .ras_full (ras_full_a),
        .halted   (halted_a)
    );

    pc_gen #(
        .ADDR_W   (16),
        .RESET_VEC(16'h0),
        .RAS_DEPTH(4),
        .HALT_EN  (1'b1),
        .HALT_ADDR(16'h0100)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .exc_req  (exc_req),
        .exc_vec  (exc_vec[15:0]),
        .br_taken (br_taken),
        .br_addr  (br_addr[15:0]),
        .jmp      (jmp),
        .jmp_imm  (jmp_imm),
        .call     (call),
        .ret      (ret),
        .jr_addr  (jr_addr[15:0]),
        .resume   (resume),
        .cur_pc   (cur_pc_b),
        .pc_plus_4(pc_plus_4_b),
        .nxt_pc   (nxt_pc_b),
        .ras_top  (ras_top_b),
        .ras_empty(ras_empty_b),
        .ras_full (ras_full_b),
        .halted   (halted_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall    = 1'b0;
        exc_req  = 1'b0;
        br_taken = 1'b0;
        jmp      = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        resume   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: index 0 = 32-bit instance, 1 = 16-bit instance
    // ------------------------------------------------------------------
    localparam int DEPTH = 4;

    longint unsigned m_pc   [2];
    bit              m_halt [2];
    longint unsigned m_stk  [2][DEPTH];
    int              m_cnt  [2];

    function automatic longint unsigned mask(int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
    endfunction

    function automatic longint unsigned halt_at(int i);
        return (i == 0) ? 64'd20 : 64'h100;
    endfunction

    function automatic longint unsigned m_p4(int i);
        return (m_pc[i] + 4) & mask(i);
    endfunction

    function automatic longint unsigned m_top(int i);
        return (m_cnt[i] == 0) ? 64'd0 : m_stk[i][m_cnt[i]-1];
    endfunction

    function automatic longint unsigned m_next(int i);
        longint unsigned region;
        if (exc_req) return longint'(exc_vec) & mask(i);
        if (ret) return (m_cnt[i] != 0) ? m_top(i) : (longint'(jr_addr) & mask(i));
        if (jmp) begin
            region = m_p4(i) & ~64'h0FFF_FFFF;
            return (region | (longint'(jmp_imm) << 2)) & mask(i);
        end
        if (br_taken && !stall) return longint'(br_addr) & mask(i);
        return m_p4(i);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]   = 0;
            m_halt[i] = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic m_step(int i);
        longint unsigned nx;
        longint unsigned p4;
        nx = m_next(i);
        p4 = m_p4(i);
        if (exc_req) begin
            m_pc[i]   = nx;
            m_halt[i] = 1'b0;
            m_cnt[i]  = 0;
        end else if (!m_halt[i]) begin
            if (!stall) begin
                m_pc[i] = nx;
                if (nx == halt_at(i)) m_halt[i] = 1'b1;
                if (call && ret) begin
                    if (m_cnt[i] == 0) begin
                        m_stk[i][0] = p4;
                        m_cnt[i]    = 1;
                    end else begin
                        m_stk[i][m_cnt[i]-1] = p4;
                    end
                end else if (call) begin
                    if (m_cnt[i] == DEPTH) begin
                        for (int k = 0; k < DEPTH - 1; k++) m_stk[i][k] = m_stk[i][k+1];
                        m_stk[i][DEPTH-1] = p4;
                    end else begin
                        m_stk[i][m_cnt[i]] = p4;
                        m_cnt[i]++;
                    end
                end else if (ret) begin
                    if (m_cnt[i] > 0) m_cnt[i]--;
                end
            end
        end else if (resume) begin
            m_halt[i] = 1'b0;
            m_pc[i]   = (halt_at(i) + 4) & mask(i);
        end
    endtask

    task automatic compare_all();
        check("a.cur_pc",    cur_pc_a,    m_pc[0]);
        check("a.pc_plus_4", pc_plus_4_a, m_p4(0));
        check("a.nxt_pc",    nxt_pc_a,    m_next(0));
        check("a.ras_top",   ras_top_a,   m_top(0));
        check("a.ras_empty", ras_empty_a, m_cnt[0] == 0);
        check("a.ras_full",  ras_full_a,  m_cnt[0] == DEPTH);
        check("a.halted",    halted_a,    m_halt[0]);
        check("b.cur_pc",    cur_pc_b,    m_pc[1]);
        check("b.pc_plus_4", pc_plus_4_b, m_p4(1));
        check("b.nxt_pc",    nxt_pc_b,    m_next(1));
        check("b.ras_top",   ras_top_b,   m_top(1));
        check("b.ras_empty", ras_empty_b, m_cnt[1] == 0);
        check("b.ras_full",  ras_full_b,  m_cnt[1] == DEPTH);
        check("b.halted",    halted_b,    m_halt[1]);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 32'd20;
            1:       return 32'h0000_0100;
            2:       return 32'hFFFF_FFFC;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    logic [31:0] ret_exp [5];

    initial begin
        idle();
        exc_vec = '0;
        br_addr = '0;
        jr_addr = '0;
        jmp_imm = '0;

        // Reset values
        rst = 1'b1;
        #2;
        check("rst.cur_pc",    cur_pc_a,    0);
        check("rst.halted",    halted_a,    0);
        check("rst.ras_empty", ras_empty_a, 1);
        check("rst.ras_full",  ras_full_a,  0);
        check("rst.ras_top",   ras_top_a,   0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("run.pc0", cur_pc_a, 0);

        // Free run from reset, halting at 20 after five edges
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("run.pc", cur_pc_a, 4 * k);
        end
        check("halt.entered", halted_a, 1);
        call = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("halt.pc",  cur_pc_a, 20);
            check("halt.flg", halted_a, 1);
        end
        check("halt.ras_frozen", ras_empty_a, 1);
        call   = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume.pc",  cur_pc_a, 24);
        check("resume.flg", halted_a, 0);

        // Branch held off by stall
        exc_req = 1'b1;
        exc_vec = 32'h40;
        tick();
        exc_req = 1'b0;
        check("br.setup", cur_pc_a, 32'h40);
        br_taken = 1'b1;
        br_addr  = 32'h100;
        stall    = 1'b1;
        #1;
        check("br.stall_nxt", nxt_pc_a, 32'h44);
        tick();
        check("br.stall_pc", cur_pc_a, 32'h40);
        stall = 1'b0;
        #1;
        check("br.nxt", nxt_pc_a, 32'h100);
        tick();
        check("br.pc", cur_pc_a, 32'h100);
        idle();

        // Five calls into a 4-deep RAS, then five returns
        exc_req = 1'b1;
        exc_vec = 32'h10;
        tick();
        idle();
        for (int k = 0; k < 5; k++) begin
            call    = 1'b1;
            jmp     = 1'b1;
            jmp_imm = 26'((32'h20 + 32'h10 * k) >> 2);
            tick();
            check("call.pc", cur_pc_a, 32'h20 + 32'h10 * k);
            check("call.top", ras_top_a, 32'h14 + 32'h10 * k);
            if (k == 2) check("call.not_full", ras_full_a, 0);
            if (k >= 3) check("call.full", ras_full_a, 1);
        end
        idle();
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h200};
        jr_addr = 32'h200;
        for (int k = 0; k < 5; k++) begin
            ret = 1'b1;
            #1;
            check("ret.nxt", nxt_pc_a, ret_exp[k]);
            tick();
            check("ret.pc", cur_pc_a, ret_exp[k]);
            if (k == 2) check("ret.not_empty", ras_empty_a, 0);
            if (k >= 3) check("ret.empty", ras_empty_a, 1);
        end
        check("ret.top_zero", ras_top_a, 0);
        idle();

        // Exception beats everything and flushes the RAS
        call = 1'b1;
        tick();
        call = 1'b0;
        check("exc.pre_ras", ras_empty_a, 0);
        exc_req = 1'b1;
        jmp     = 1'b1;
        ret     = 1'b1;
        stall   = 1'b1;
        exc_vec = 32'h180;
        #1;
        check("exc.nxt", nxt_pc_a, 32'h180);
        tick();
        check("exc.pc",  cur_pc_a, 32'h180);
        check("exc.ras", ras_empty_a, 1);
        idle();

        // Call and return in the same cycle
        exc_req = 1'b1;
        exc_vec = 32'h300;
        tick();
        idle();
        call    = 1'b1;
        ret     = 1'b1;
        jr_addr = 32'h400;
        #1;
        check("cr.nxt_empty", nxt_pc_a, 32'h400);
        tick();
        check("cr.pc1",  cur_pc_a, 32'h400);
        check("cr.top1", ras_top_a, 32'h304);
        #1;
        check("cr.nxt_top", nxt_pc_a, 32'h304);
        tick();
        check("cr.top2", ras_top_a, 32'h404);
        call = 1'b0;
        #1;
        check("cr.nxt_pop", nxt_pc_a, 32'h404);
        tick();
        check("cr.pc3",   cur_pc_a, 32'h404);
        check("cr.empty", ras_empty_a, 1);
        idle();

        // 16-bit wrap, then reset while halted
        exc_req = 1'b1;
        exc_vec = 32'h0001_FFFC;
        tick();
        idle();
        check("w16.pc",    cur_pc_b, 16'hFFFC);
        check("w16.p4",    pc_plus_4_b, 16'h0000);
        tick();
        check("w16.wrap",  cur_pc_b, 16'h0000);
        check("w32.nowrap", cur_pc_a, 32'h0002_0000);
        exc_req = 1'b1;
        exc_vec = 32'hFC;
        tick();
        idle();
        tick();
        check("h16.pc",  cur_pc_b, 16'h0100);
        check("h16.flg", halted_b, 1);
        tick();
        check("h16.hold", cur_pc_b, 16'h0100);
        rst = 1'b1;
        #1;
        check("h16.rst_pc",  cur_pc_b, 0);
        check("h16.rst_flg", halted_b, 0);
        check("h32.rst_pc",  cur_pc_a, 0);
        rst = 1'b0;
        m_reset();
        #1;

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle();
                rst = 1'b1;
                #1;
                m_reset();
                compare_all();
                rst = 1'b0;
                #1;
            end
            stall    = ($urandom_range(0, 3) == 0);
            exc_req  = ($urandom_range(0, 15) == 0);
            call     = ($urandom_range(0, 3) == 0);
            ret      = ($urandom_range(0, 3) == 0);
            jmp      = ($urandom_range(0, 7) == 0);
            br_taken = ($urandom_range(0, 3) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            exc_vec  = pick_addr();
            br_addr  = pick_addr();
            jr_addr  = pick_addr();
            jmp_imm  = 26'($urandom);
            #1;
            compare_all();
            @(posedge clk);
            m_step(0);
            m_step(1);
            #1;
        end
        idle();
        #1;
        compare_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
